// File: rtl/keypad_encoder.sv
// ============================================================================
// Module      : keypad_encoder
// Description : Scans, debounces and BCD-encodes a 10-key pad and emits a one-cycle
//               load strobe. Optional 2-flop input synchroniser: KEYPAD_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [9:0] keypad,
  input  logic       enable,
  input  logic       digit_clr,
  output logic [3:0] bcd_out,
  output logic       load,
  output logic [1:0] digit_count,
  output logic       key_error
);

  localparam int            DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [1:0]    CMAX = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    FIRE     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [9:0]    ks;
  logic [9:0]    ks_q;
  logic [DW-1:0] dcnt;
  logic          one_hot;
  logic          multi;
  logic          fire_ok;
  logic [3:0]    enc;

`ifdef KEYPAD_SYNC_EN
  logic [9:0] sync1;
  logic [9:0] sync2;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
    end
  end

  assign ks = sync2;
`else
  assign ks = keypad;
`endif

  assign one_hot = (ks != 10'd0) && ((ks & (ks - 10'd1)) == 10'd0);
  assign multi   = (ks != 10'd0) && !one_hot;

  // dcnt counts consecutive cycles in which ks has held the same value
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ks_q      <= '0;
      dcnt      <= '0;
      key_error <= 1'b0;
    end else begin
      ks_q      <= ks;
      key_error <= multi;
      if (ks != ks_q)
        dcnt <= '0;
      else if (dcnt != DMAX)
        dcnt <= dcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fire_ok  = 1'b0;
    enc      = 4'd0;
    // ks_q holds the qualified key throughout FIRE even if ks moves on
    for (int k = 0; k < 10; k++) begin
      if (ks_q[k]) enc = 4'(k);
    end
    case (state)
      IDLE: begin
        if (one_hot) state_nx = QUAL;
      end
      QUAL: begin
        if ((ks != ks_q) || !one_hot) state_nx = IDLE;
        else if (dcnt == DMAX)        state_nx = FIRE;
      end
      FIRE: begin
        fire_ok  = enable && (digit_count < CMAX);
        state_nx = WAIT_REL;
      end
      WAIT_REL: begin
        if ((ks == 10'd0) && (dcnt == DMAX)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      load        <= 1'b0;
      bcd_out     <= 4'd0;
      digit_count <= 2'd0;
    end else begin
      load <= fire_ok;
      if (fire_ok) bcd_out <= enc;
      if (digit_clr)
        digit_count <= fire_ok ? 2'd1 : 2'd0;
      else if (fire_ok)
        digit_count <= digit_count + 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: scoreboarded load strobes plus directed checks.
`default_nettype none

module tb_keypad_encoder;

  localparam int DEB = 4;
`ifdef KEYPAD_SYNC_EN
  localparam int LAT = DEB + 4;
`else
  localparam int LAT = DEB + 2;
`endif

  logic       clk = 1'b0;
  logic       clear_n;
  logic [9:0] keypad;
  logic       enable;
  logic       digit_clr;
  logic [3:0] bcd_out;
  logic       load;
  logic [1:0] digit_count;
  logic       key_error;

  keypad_encoder #(.DEBOUNCE_CYCLES(DEB), .MAX_DIGITS(3)) dut (
    .clk(clk), .clear_n(clear_n), .keypad(keypad), .enable(enable),
    .digit_clr(digit_clr), .bcd_out(bcd_out), .load(load),
    .digit_count(digit_count), .key_error(key_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bcd;
    logic [1:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock; any load seen is matched against the oldest scoreboard entry
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (load === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("load_cycle", cyc, e.cyc);
        check("bcd_out", {28'd0, bcd_out}, {28'd0, e.bcd});
        check("digit_count", {30'd0, digit_count}, {30'd0, e.cnt});
      end
    end
  endtask

  task automatic press(input logic [9:0] k, input int hold, input int rel, input bit exp_load,
                       input logic [3:0] b, input logic [1:0] n, input int clr_idx);
    keypad = k;
    if (exp_load) sb.push_back('{bcd: b, cnt: n, cyc: cyc + 1 + LAT});
    for (int i = 0; i < hold; i++) begin
      digit_clr = (i == clr_idx);
      tick();
    end
    digit_clr = 1'b0;
    keypad    = 10'd0;
    for (int i = 0; i < rel; i++) tick();
    check("pending_loads", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    clear_n   = 1'b1;
    keypad    = 10'd0;
    enable    = 1'b1;
    digit_clr = 1'b0;
    #2 clear_n = 1'b0;
    #1;
    check("rst_bcd_out", {28'd0, bcd_out}, 32'd0);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_digit_count", {30'd0, digit_count}, 32'd0);
    check("rst_key_error", {31'd0, key_error}, 32'd0);
    tick();
    tick();
    clear_n = 1'b1;
    tick();

    // single held key: one load only
    press(10'b0000100000, 20, 10, 1'b1, 4'd5, 2'd1, -1);
    check("t1_count", {30'd0, digit_count}, 32'd1);

    // bouncing key 7 never qualifies
    for (int j = 0; j < 6; j++) begin
      keypad = (j % 2 == 0) ? 10'b0010000000 : 10'd0;
      tick();
      tick();
    end
    keypad = 10'd0;
    for (int j = 0; j < 10; j++) tick();
    check("t2_count", {30'd0, digit_count}, 32'd1);

    // two keys together: key_error, no load
    keypad = 10'b0000001100;
    for (int j = 0; j < 5; j++) tick();
    check("t3_key_error_set", {31'd0, key_error}, 32'd1);
    for (int j = 0; j < 15; j++) tick();
    keypad = 10'd0;
    for (int j = 0; j < 6; j++) tick();
    check("t3_key_error_clr", {31'd0, key_error}, 32'd0);
    for (int j = 0; j < 4; j++) tick();

    // digit limit and digit_clr
    digit_clr = 1'b1;
    tick();
    digit_clr = 1'b0;
    check("t4_clr_count", {30'd0, digit_count}, 32'd0);
    check("t4_clr_bcd_held", {28'd0, bcd_out}, 32'd5);
    press(10'b0000000010, 10, 10, 1'b1, 4'd1, 2'd1, -1);
    press(10'b0000000100, 10, 10, 1'b1, 4'd2, 2'd2, -1);
    press(10'b0000001000, 10, 10, 1'b1, 4'd3, 2'd3, -1);
    press(10'b0000010000, 10, 10, 1'b0, 4'd0, 2'd0, -1);
    check("t4_sat_count", {30'd0, digit_count}, 32'd3);
    check("t4_sat_bcd", {28'd0, bcd_out}, 32'd3);
    digit_clr = 1'b1;
    tick();
    digit_clr = 1'b0;
    check("t4_clr2_count", {30'd0, digit_count}, 32'd0);
    check("t4_clr2_bcd_held", {28'd0, bcd_out}, 32'd3);
    press(10'b0000010000, 10, 10, 1'b1, 4'd4, 2'd1, -1);

    // async reset while qualifying key 9; key must re-qualify fully
    keypad = 10'b1000000000;
    for (int j = 0; j < 4; j++) tick();
    clear_n = 1'b0;
    #1;
    check("t5_rst_bcd_out", {28'd0, bcd_out}, 32'd0);
    check("t5_rst_load", {31'd0, load}, 32'd0);
    check("t5_rst_digit_count", {30'd0, digit_count}, 32'd0);
    check("t5_rst_key_error", {31'd0, key_error}, 32'd0);
    tick();
    tick();
    clear_n = 1'b1;
    sb.push_back('{bcd: 4'd9, cnt: 2'd1, cyc: cyc + 1 + LAT});
    for (int j = 0; j < 20; j++) tick();
    keypad = 10'd0;
    for (int j = 0; j < 10; j++) tick();
    check("t5_pending_loads", sb.size(), 32'd0);
    sb.delete();

    // enable gating
    enable = 1'b0;
    press(10'b0001000000, 15, 10, 1'b0, 4'd0, 2'd0, -1);
    check("t6_disabled_count", {30'd0, digit_count}, 32'd1);
    enable = 1'b1;
    press(10'b0001000000, 15, 10, 1'b1, 4'd6, 2'd2, -1);

    // digit_clr coinciding with FIRE: load still fires, count ends at 1
    press(10'b0100000000, 15, 10, 1'b1, 4'd8, 2'd1, LAT);
    check("t7_count", {30'd0, digit_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
